// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter. These are the arbiter FSM states,
// the read owner, and the read tag that travels alongside each in-flight load.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    // Arbiter FSM: idle (vector command accepted here) or streaming a burst.
    typedef enum logic {
        IDLE   = 1'b0,
        VBURST = 1'b1
    } arb_state_t;

    // Requester that issued a read; selects which rvalid fires on return.
    typedef enum logic {
        OWN_SCALAR = 1'b0,
        OWN_VECTOR = 1'b1
    } owner_t;

    // Tag carried through the read-latency pipe for every issued access.
    typedef struct packed {
        logic   valid;   // access was a read; data will come back
        owner_t owner;   // who gets the data
        logic   last;    // final beat of a vector burst
    } rd_tag_t;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// dmem_rd_tag_pipe
// DEPTH-deep shift register of read tags. A tag pushed in the issue cycle
// leaves the pipe exactly when the memory presents that read's data.
//
// Ports:
//   clk      - clock
//   reset    - asynchronous active-low reset; clears all tags
//   pushTag  - tag of the access issued this cycle (valid=0 for writes/idle)
//   popTag   - tag whose read data is on mem_rd this cycle
//   anyValid - at least one read is still in flight
// -----------------------------------------------------------------------------
module dmem_rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t pushTag,
    output rd_tag_t popTag,
    output logic    anyValid
);

    rd_tag_t stage [DEPTH];

    // NOTE: this storage is reset on purpose, unlike a data RAM: clearing the
    // valid bits is what drops in-flight reads when reset hits mid-burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= pushTag;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign popTag = stage[DEPTH-1];

    always_comb begin
        anyValid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            anyValid = anyValid | stage[i].valid;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the scalar memory stage (one beat
// per access) and the vector LSU (bursts of BURST_LEN beats). Scalar has
// priority, but a pending vector beat may lose at most MAX_WAIT cycles in a
// row. Read data is routed back to its issuer using tags that travel through
// an RD_LAT-deep pipe.
//
// Configuration:
//   DMEM_ARB_STATS_EN - when defined, stat_conflicts is a saturating count of
//                       contended cycles; otherwise it is tied to zero.
//
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   s_valid/s_we/s_addr/s_wdata  - scalar request
//   s_ready             - scalar access issued this cycle
//   s_rvalid/s_rdata    - scalar read return
//   v_valid/v_we/v_base - vector burst command, v_ready accepts it
//   v_wdata/v_wpop      - store beat data and its consume strobe
//   v_rvalid/v_rdata/v_rlast - vector read beat return
//   mem_we/mem_addr/mem_wd/mem_rd - single-port memory interface
//   busy                - burst active or reads in flight
//   stat_conflicts      - contention counter (optional)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 64,
    parameter int DW        = 64,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 1,
    parameter int MAX_WAIT  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    input  logic          s_we,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_wdata,
    output logic          s_ready,
    output logic          s_rvalid,
    output logic [DW-1:0] s_rdata,
    input  logic          v_valid,
    input  logic          v_we,
    input  logic [AW-1:0] v_base,
    output logic          v_ready,
    input  logic [DW-1:0] v_wdata,
    output logic          v_wpop,
    output logic          v_rvalid,
    output logic [DW-1:0] v_rdata,
    output logic          v_rlast,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy,
    output logic [15:0]   stat_conflicts
);

    localparam int BW     = $clog2(BURST_LEN);
    localparam int WW     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int STRIDE = DW / 8;

    arb_state_t    state;
    logic [BW-1:0] beatCnt;
    logic [WW-1:0] waitCnt;
    logic          vWeQ;
    logic [AW-1:0] vBaseQ;

    logic          vecPending;
    logic          forceVec;
    logic          scalarGrant;
    logic          vecGrant;
    logic          lastBeat;
    logic [AW-1:0] vecAddr;
    rd_tag_t       pushTag;
    rd_tag_t       popTag;
    logic          tagBusy;

    // Grant decision. Reset forces state to IDLE asynchronously, so gating the
    // scalar grant with reset is enough to hold every issue output at zero.
    // NOTE: every always_comb output gets a default at the top so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        vecPending  = (state == VBURST);
        forceVec    = vecPending && (waitCnt == WW'(MAX_WAIT));
        scalarGrant = reset && s_valid && !forceVec;
        vecGrant    = vecPending && !scalarGrant;
        lastBeat    = (beatCnt == BW'(BURST_LEN - 1));
        // Address wraps modulo 2^AW by construction of the AW-bit add.
        vecAddr     = vBaseQ + (AW'(beatCnt) * AW'(STRIDE));

        pushTag       = '0;
        pushTag.valid = (scalarGrant && !s_we) || (vecGrant && !vWeQ);
        pushTag.owner = vecGrant ? OWN_VECTOR : OWN_SCALAR;
        pushTag.last  = vecGrant && lastBeat;
    end

    // Burst FSM with beat and starvation counters.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            beatCnt <= '0;
            waitCnt <= '0;
            vWeQ    <= 1'b0;
            vBaseQ  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (v_valid) begin
                        vWeQ    <= v_we;
                        vBaseQ  <= v_base;
                        beatCnt <= '0;
                        waitCnt <= '0;
                        state   <= VBURST;
                    end
                end
                VBURST: begin
                    if (vecGrant) begin
                        waitCnt <= '0;
                        if (lastBeat) begin
                            beatCnt <= '0;
                            state   <= IDLE;
                        end else begin
                            beatCnt <= beatCnt + BW'(1);
                        end
                    end else if (scalarGrant) begin
                        waitCnt <= waitCnt + WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dmem_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .pushTag  (pushTag),
        .popTag   (popTag),
        .anyValid (tagBusy)
    );

    // Issue side.
    assign s_ready  = scalarGrant;
    assign v_ready  = reset && (state == IDLE);
    assign v_wpop   = vecGrant && vWeQ;
    assign mem_we   = scalarGrant ? s_we : v_wpop;
    assign mem_addr = scalarGrant ? s_addr  : (vecGrant ? vecAddr : '0);
    assign mem_wd   = scalarGrant ? s_wdata : (v_wpop ? v_wdata : '0);

    // Return side: the tag leaving the pipe belongs to the data on mem_rd.
    assign s_rvalid = popTag.valid && (popTag.owner == OWN_SCALAR);
    assign v_rvalid = popTag.valid && (popTag.owner == OWN_VECTOR);
    assign v_rlast  = v_rvalid && popTag.last;
    assign s_rdata  = s_rvalid ? mem_rd : '0;
    assign v_rdata  = v_rvalid ? mem_rd : '0;

    assign busy = vecPending || tagBusy;

`ifdef DMEM_ARB_STATS_EN
    logic        conflict;
    logic [15:0] statCnt;

    // Contended cycle: scalar jumped a pending beat, or scalar was held off.
    assign conflict = (vecPending && scalarGrant) || (reset && s_valid && !scalarGrant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            statCnt <= '0;
        end else if (conflict && (statCnt != 16'hFFFF)) begin
            statCnt <= statCnt + 16'd1;
        end
    end

    assign stat_conflicts = statCnt;
`else
    assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with default parameters (AW=DW=64,
// BURST_LEN=4, RD_LAT=1, MAX_WAIT=3). A behavioural memory returns stored
// data, or ~address for locations never written.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid, s_we;
    logic [63:0] s_addr, s_wdata;
    logic        s_ready, s_rvalid;
    logic [63:0] s_rdata;
    logic        v_valid, v_we;
    logic [63:0] v_base, v_wdata;
    logic        v_ready, v_wpop, v_rvalid, v_rlast;
    logic [63:0] v_rdata;
    logic        mem_we;
    logic [63:0] mem_addr, mem_wd, mem_rd;
    logic        busy;
    logic [15:0] stat_conflicts;

    int checks   = 0;
    int failures = 0;
    int wpopCount = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_we           (s_we),
        .s_addr         (s_addr),
        .s_wdata        (s_wdata),
        .s_ready        (s_ready),
        .s_rvalid       (s_rvalid),
        .s_rdata        (s_rdata),
        .v_valid        (v_valid),
        .v_we           (v_we),
        .v_base         (v_base),
        .v_ready        (v_ready),
        .v_wdata        (v_wdata),
        .v_wpop         (v_wpop),
        .v_rvalid       (v_rvalid),
        .v_rdata        (v_rdata),
        .v_rlast        (v_rlast),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wd         (mem_wd),
        .mem_rd         (mem_rd),
        .busy           (busy),
        .stat_conflicts (stat_conflicts)
    );

    // Memory model: one-cycle read latency, write on the same edge.
    logic [63:0] memArr [logic [63:0]];

    function automatic logic [63:0] readMem(input logic [63:0] a);
        if (memArr.exists(a)) return memArr[a];
        return ~a;
    endfunction

    always @(posedge clk) begin
        mem_rd <= readMem(mem_addr);
        if (mem_we) memArr[mem_addr] = mem_wd;
        if (v_wpop) wpopCount++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        s_valid = 0; s_we = 0; s_addr = '0; s_wdata = '0;
        v_valid = 0; v_we = 0; v_base = '0; v_wdata = '0;
    endtask

    typedef struct {
        logic        sValid, sWe;
        logic [63:0] sAddr, sWdata;
        logic        vValid, vWe;
        logic [63:0] vBase, vWdata;
        logic        eSReady, eVReady, eMemWe;
        logic [63:0] eMemAddr, eMemWd;
        logic        eSRvalid, eVRvalid, eVRlast;
        logic [63:0] eRdata;
        logic        eBusy, eWpop;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(
        input logic sV, input logic sW, input logic [63:0] sA, input logic [63:0] sD,
        input logic vV, input logic vW, input logic [63:0] vB, input logic [63:0] vD,
        input logic eSr, input logic eVr, input logic eWe,
        input logic [63:0] eA, input logic [63:0] eWd,
        input logic eSrv, input logic eVrv, input logic eLast,
        input logic [63:0] eRd, input logic eBusy, input logic ePop);
        vec_t r;
        r.sValid = sV; r.sWe = sW; r.sAddr = sA; r.sWdata = sD;
        r.vValid = vV; r.vWe = vW; r.vBase = vB; r.vWdata = vD;
        r.eSReady = eSr; r.eVReady = eVr; r.eMemWe = eWe;
        r.eMemAddr = eA; r.eMemWd = eWd;
        r.eSRvalid = eSrv; r.eVRvalid = eVrv; r.eVRlast = eLast;
        r.eRdata = eRd; r.eBusy = eBusy; r.eWpop = ePop;
        return r;
    endfunction

    logic [15:0] statBefore;
    logic [63:0] wrapBase;

    initial begin
        wrapBase = 64'hFFFF_FFFF_FFFF_FFF8;
        memArr[64'h40] = 64'hDEAD_BEEF;

        // Scalar read/write, vector load 0x100, simultaneous scalar + vector
        // store command with address wrap.
        //            sV sW sAddr   sWdata  vV vW vBase     vWdata  sRdy vRdy we addr        wd      sRv vRv last rdata                 busy pop
        tbl[0]  = mk(1, 0, 64'h40, 64'h0,  0, 0, 64'h0,    64'h0,  1,   1,   0, 64'h40,     64'h0,  0,  0,  0,   64'h0,                0,   0);
        tbl[1]  = mk(1, 1, 64'h80, 64'h1234, 0, 0, 64'h0,  64'h0,  1,   1,   1, 64'h80,     64'h1234, 1, 0, 0,   64'hDEAD_BEEF,        1,   0);
        tbl[2]  = mk(0, 0, 64'h0,  64'h0,  1, 0, 64'h100,  64'h0,  0,   1,   0, 64'h0,      64'h0,  0,  0,  0,   64'h0,                0,   0);
        tbl[3]  = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'h0,  0,   0,   0, 64'h100,    64'h0,  0,  0,  0,   64'h0,                1,   0);
        tbl[4]  = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'h0,  0,   0,   0, 64'h108,    64'h0,  0,  1,  0,   ~64'h100,             1,   0);
        tbl[5]  = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'h0,  0,   0,   0, 64'h110,    64'h0,  0,  1,  0,   ~64'h108,             1,   0);
        tbl[6]  = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'h0,  0,   0,   0, 64'h118,    64'h0,  0,  1,  0,   ~64'h110,             1,   0);
        tbl[7]  = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'h0,  0,   1,   0, 64'h0,      64'h0,  0,  1,  1,   ~64'h118,             1,   0);
        tbl[8]  = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'h0,  0,   1,   0, 64'h0,      64'h0,  0,  0,  0,   64'h0,                0,   0);
        tbl[9]  = mk(1, 0, 64'h80, 64'h0,  1, 1, wrapBase, 64'h0,  1,   1,   0, 64'h80,     64'h0,  0,  0,  0,   64'h0,                0,   0);
        tbl[10] = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'hA0, 0,   0,   1, wrapBase,   64'hA0, 1,  0,  0,   64'h1234,             1,   1);
        tbl[11] = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'hA1, 0,   0,   1, 64'h0,      64'hA1, 0,  0,  0,   64'h0,                1,   1);
        tbl[12] = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'hA2, 0,   0,   1, 64'h8,      64'hA2, 0,  0,  0,   64'h0,                1,   1);
        tbl[13] = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'hA3, 0,   0,   1, 64'h10,     64'hA3, 0,  0,  0,   64'h0,                1,   1);
        tbl[14] = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    64'h0,  0,   1,   0, 64'h0,      64'h0,  0,  0,  0,   64'h0,                0,   0);

        // Reset state.
        idleInputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst v_ready", 64'(v_ready), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst mem_addr", mem_addr, 64'd0);
        check("rst rvalid", 64'({s_rvalid, v_rvalid}), 64'd0);
        reset = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            s_valid = tbl[i].sValid; s_we = tbl[i].sWe;
            s_addr  = tbl[i].sAddr;  s_wdata = tbl[i].sWdata;
            v_valid = tbl[i].vValid; v_we = tbl[i].vWe;
            v_base  = tbl[i].vBase;  v_wdata = tbl[i].vWdata;
            @(negedge clk);
            check($sformatf("v%0d s_ready", i), 64'(s_ready), 64'(tbl[i].eSReady));
            check($sformatf("v%0d v_ready", i), 64'(v_ready), 64'(tbl[i].eVReady));
            check($sformatf("v%0d mem_we", i), 64'(mem_we), 64'(tbl[i].eMemWe));
            check($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].eMemAddr);
            check($sformatf("v%0d s_rvalid", i), 64'(s_rvalid), 64'(tbl[i].eSRvalid));
            check($sformatf("v%0d v_rvalid", i), 64'(v_rvalid), 64'(tbl[i].eVRvalid));
            check($sformatf("v%0d v_rlast", i), 64'(v_rlast), 64'(tbl[i].eVRlast));
            check($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].eBusy));
            check($sformatf("v%0d v_wpop", i), 64'(v_wpop), 64'(tbl[i].eWpop));
            if (tbl[i].eMemWe)   check($sformatf("v%0d mem_wd", i), mem_wd, tbl[i].eMemWd);
            if (tbl[i].eSRvalid) check($sformatf("v%0d s_rdata", i), s_rdata, tbl[i].eRdata);
            if (tbl[i].eVRvalid) check($sformatf("v%0d v_rdata", i), v_rdata, tbl[i].eRdata);
        end
        check("wpop pulses", 64'(wpopCount), 64'd4);

        // Starvation: scalar held high across a load burst at 0x200.
        @(posedge clk); #1;
        idleInputs();
        s_valid = 1; s_addr = 64'h300;
        v_valid = 1; v_base = 64'h200;
        @(negedge clk);
        check("starve accept v_ready", 64'(v_ready), 64'd1);
        check("starve accept s_ready", 64'(s_ready), 64'd1);
        statBefore = stat_conflicts;
        @(posedge clk); #1;
        v_valid = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("starve c%0d s_ready", k), 64'(s_ready), 64'((k % 4) != 3));
            check($sformatf("starve c%0d mem_addr", k), mem_addr,
                  ((k % 4) == 3) ? 64'h200 + 64'(8 * (k / 4)) : 64'h300);
            if (k < 15) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        s_valid = 0;
        @(negedge clk);
        check("starve done v_ready", 64'(v_ready), 64'd1);
`ifdef DMEM_ARB_STATS_EN
        check("stat_conflicts delta", 64'(stat_conflicts - statBefore), 64'd16);
`else
        check("stat_conflicts tied", 64'(stat_conflicts), 64'd0);
`endif

        // Reset in the middle of a load burst at 0x400.
        @(posedge clk); #1;
        v_valid = 1; v_base = 64'h400;
        @(posedge clk); #1;
        v_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst beat1 addr", mem_addr, 64'h408);
        @(posedge clk); #1;
        reset = 1'b0;
        s_valid = 1; s_we = 1; s_addr = 64'h55; s_wdata = 64'h1;
        #1;
        check("midrst s_ready", 64'(s_ready), 64'd0);
        check("midrst v_ready", 64'(v_ready), 64'd0);
        check("midrst mem_we", 64'(mem_we), 64'd0);
        check("midrst mem_addr", mem_addr, 64'd0);
        check("midrst mem_wd", mem_wd, 64'd0);
        check("midrst rvalid", 64'({s_rvalid, v_rvalid, v_rlast}), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst wpop", 64'(v_wpop), 64'd0);
        check("midrst stat", 64'(stat_conflicts), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idleInputs();
        v_valid = 1; v_we = 1; v_base = 64'h800; v_wdata = 64'hB0;
        #1;
        check("postrst v_ready", 64'(v_ready), 64'd1);
        @(posedge clk); #1;
        v_valid = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("postrst c%0d rvalid", k), 64'({s_rvalid, v_rvalid}), 64'd0);
            if (k == 0) begin
                check("postrst beat0 addr", mem_addr, 64'h800);
                check("postrst beat0 we", 64'(mem_we), 64'd1);
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
